// File: rtl/ws2812_frame_sequencer_if.sv
// Signal bundle between the frame sequencer, the pixel buffer and the WS2812 bit controller.
// The sequencer takes the master view; the application and bit controller side takes the slave view.
interface ws2812_frame_sequencer_if #(
    parameter int AW = 3
);
    logic          frame_start;
    logic          busy;
    logic          frame_done;
    logic          pix_rd;
    logic [AW-1:0] pix_addr;
    logic [23:0]   pix_data;
    logic [23:0]   bc_data;
    logic          bc_load;
    logic          bc_done;

    modport master (
        input  frame_start,
        input  pix_data,
        input  bc_done,
        output busy,
        output frame_done,
        output pix_rd,
        output pix_addr,
        output bc_data,
        output bc_load
    );

    modport slave (
        output frame_start,
        output pix_data,
        output bc_done,
        input  busy,
        input  frame_done,
        input  pix_rd,
        input  pix_addr,
        input  bc_data,
        input  bc_load
    );
endinterface

// File: rtl/ws2812_frame_sequencer.sv
// WS2812 frame sequencer: streams NUM_LEDS GRB words from a synchronous-read buffer into the
// single-word bit controller, then holds the line low for the latch gap before reporting completion.
module ws2812_frame_sequencer #(
    parameter int F_CLK    = 12_000_000,
    parameter int NUM_LEDS = 8,
    parameter int RESET_US = 60
) (
    input  logic                            CLK_IN,
    input  logic                            reset,
    ws2812_frame_sequencer_if.master        bus
);
    localparam int AW           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int LATCH_CYCLES = (F_CLK / 1_000_000) * RESET_US;
    localparam int CW           = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_LEDS - 1);

    localparam logic [2:0] S_LATCH = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_SEND  = 3'd4;

    logic [2:0]    state_q,       state_d;
    logic [AW-1:0] idx_q,         idx_d;
    logic [CW-1:0] cnt_q,         cnt_d;
    logic [1:0]    guard_q,       guard_d;
    logic          pending_q,     pending_d;
    logic          after_frame_q, after_frame_d;
    logic [23:0]   bc_data_q,     bc_data_d;
    logic          bc_load_q,     bc_load_d;
    logic          frame_done_q,  frame_done_d;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        guard_d       = guard_q;
        pending_d     = pending_q;
        after_frame_d = after_frame_q;
        bc_data_d     = bc_data_q;
        bc_load_d     = 1'b0;
        frame_done_d  = 1'b0;

        // One-deep request queue; this also catches a request on the LATCH exit cycle.
        if (bus.frame_start && (state_q != S_IDLE)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.frame_start || pending_q) begin
                    state_d   = S_FETCH;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end
            end

            S_FETCH: begin
                state_d = S_LOAD;
            end

            S_LOAD: begin
                bc_data_d = bus.pix_data;
                bc_load_d = 1'b1;
                guard_d   = 2'd2;
                state_d   = S_SEND;
            end

            S_SEND: begin
                // The guard masks the stale done level until the bit controller has reacted to the load.
                if (guard_q != 2'd0) begin
                    guard_d = guard_q - 2'd1;
                end else if (bus.bc_done) begin
                    if (idx_q == LAST_IDX) begin
                        cnt_d         = '0;
                        after_frame_d = 1'b1;
                        state_d       = S_LATCH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end

            S_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d       = S_IDLE;
                    frame_done_d  = after_frame_q;
                    after_frame_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_LATCH;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (reset) begin
            state_q       <= S_LATCH;
            idx_q         <= '0;
            cnt_q         <= '0;
            guard_q       <= '0;
            pending_q     <= 1'b0;
            after_frame_q <= 1'b0;
            bc_data_q     <= '0;
            bc_load_q     <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            guard_q       <= guard_d;
            pending_q     <= pending_d;
            after_frame_q <= after_frame_d;
            bc_data_q     <= bc_data_d;
            bc_load_q     <= bc_load_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.pix_rd     = (state_q == S_FETCH);
    assign bus.pix_addr   = idx_q;
    assign bus.bc_data    = bc_data_q;
    assign bus.bc_load    = bc_load_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Directed bench for ws2812_frame_sequencer with NUM_LEDS=4 and a 720-cycle latch gap.
module tb_ws2812_frame_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic fs = 1'b0;
    logic stuck = 1'b1;
    logic [23:0] rd_data;
    logic bdone;
    int   bcnt;
    int   cyc = 0;

    int nvec = 0;
    int nmis = 0;

    logic [23:0] words [4];

    int          ld_win [$];
    logic [23:0] ld_dat [$];
    int          rd_win [$];
    int          rd_adr [$];
    int          fd_win [$];
    int          dbl_ld = 0;
    int          dbl_fd = 0;
    logic        prev_ld = 1'b0;
    logic        prev_fd = 1'b0;

    ws2812_frame_sequencer_if #(.AW(2)) bus ();

    assign bus.frame_start = fs;
    assign bus.pix_data    = rd_data;
    assign bus.bc_done     = bdone;

    ws2812_frame_sequencer #(
        .F_CLK(12_000_000),
        .NUM_LEDS(4),
        .RESET_US(60)
    ) dut (
        .CLK_IN(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel buffer with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.pix_rd) rd_data <= words[bus.pix_addr];
    end

    // Bit controller: done falls one cycle after load and rises 288 cycles later.
    always @(posedge clk) begin
        if (reset || stuck) begin
            bdone <= 1'b1;
            bcnt  <= 0;
        end else if (bus.bc_load) begin
            bdone <= 1'b0;
            bcnt  <= 288;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) bdone <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (bus.bc_load) begin
            ld_win.push_back(cyc);
            ld_dat.push_back(bus.bc_data);
        end
        if (bus.pix_rd) begin
            rd_win.push_back(cyc);
            rd_adr.push_back(int'(bus.pix_addr));
        end
        if (bus.frame_done) fd_win.push_back(cyc);
        if (bus.bc_load && prev_ld) dbl_ld++;
        if (bus.frame_done && prev_fd) dbl_fd++;
        prev_ld = bus.bc_load;
        prev_fd = bus.frame_done;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required end before 50000", cyc);
        $fatal(1);
    end

    typedef struct {
        int          off;
        logic        fs;
        logic        busy;
        logic        rd;
        logic [1:0]  addr;
        logic        ld;
        logic [23:0] dat;
        logic        fd;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic wait_until(input int t);
        if (cyc > t) begin
            nvec++;
            nmis++;
            $display("FAIL sched: at cyc %0d, expected at most %0d", cyc, t);
        end
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_fd(input int n, input int limit);
        while (fd_win.size() < n && cyc < limit) @(negedge clk);
        chk("fd_timeout", fd_win.size() >= n, 1);
    endtask

    task automatic pulse_start(input int w);
        wait_until(w);
        fs = 1'b1;
        @(negedge clk);
        fs = 1'b0;
    endtask

    task automatic clear_q();
        ld_win.delete();
        ld_dat.delete();
        rd_win.delete();
        rd_adr.delete();
        fd_win.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_fd"},   bus.frame_done, 0);
        chk({tag, "_rd"},   bus.pix_rd, 0);
        chk({tag, "_addr"}, bus.pix_addr, 0);
        chk({tag, "_dat"},  bus.bc_data, 0);
        chk({tag, "_ld"},   bus.bc_load, 0);
    endtask

    initial begin
        int k;
        int r;

        words[0] = 24'h110000;
        words[1] = 24'h002200;
        words[2] = 24'h000033;
        words[3] = 24'hFFFFFF;

        //            off  fs    busy  rd    addr  ld    dat           fd
        vecs[0]  = '{ -1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 24'h000000, 1'b0};
        vecs[1]  = '{  0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 24'h000000, 1'b0};
        vecs[2]  = '{  1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 24'h000000, 1'b0};
        vecs[3]  = '{  2, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 24'h110000, 1'b0};
        vecs[4]  = '{  3, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 24'h110000, 1'b0};
        vecs[5]  = '{  4, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 24'h110000, 1'b0};
        vecs[6]  = '{  5, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 24'h110000, 1'b0};
        vecs[7]  = '{  6, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 24'h110000, 1'b0};
        vecs[8]  = '{  7, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 24'h002200, 1'b0};
        vecs[9]  = '{ 10, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 24'h002200, 1'b0};
        vecs[10] = '{ 12, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 24'h000033, 1'b0};
        vecs[11] = '{ 15, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 24'h000033, 1'b0};
        vecs[12] = '{ 17, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 24'hFFFFFF, 1'b0};
        vecs[13] = '{ 18, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 24'hFFFFFF, 1'b0};
        vecs[14] = '{ 20, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 24'hFFFFFF, 1'b0};
        vecs[15] = '{739, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 24'hFFFFFF, 1'b0};
        vecs[16] = '{740, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 24'hFFFFFF, 1'b1};
        vecs[17] = '{741, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 24'hFFFFFF, 1'b0};
        vecs[18] = '{742, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 24'hFFFFFF, 1'b0};
        vecs[19] = '{743, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 24'h110000, 1'b0};

        // Power-up latch with no request.
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        r = cyc;
        reset = 1'b0;
        wait_until(r + 360);
        chk("t1_busy_mid", bus.busy, 1);
        wait_until(r + 719);
        chk("t1_busy_last", bus.busy, 1);
        wait_until(r + 720);
        chk("t1_busy_fall", bus.busy, 0);
        wait_until(r + 725);
        chk("t1_no_fd", fd_win.size(), 0);

        // Stuck-high done: cycle-exact frame, then a request on the LATCH exit cycle.
        clear_q();
        k = cyc + 2;
        foreach (vecs[i]) begin
            wait_until(k + vecs[i].off);
            chk($sformatf("v%0d_busy", i), bus.busy, vecs[i].busy);
            chk($sformatf("v%0d_rd", i), bus.pix_rd, vecs[i].rd);
            if (vecs[i].rd) chk($sformatf("v%0d_addr", i), bus.pix_addr, vecs[i].addr);
            chk($sformatf("v%0d_ld", i), bus.bc_load, vecs[i].ld);
            chk($sformatf("v%0d_dat", i), bus.bc_data, vecs[i].dat);
            chk($sformatf("v%0d_fd", i), bus.frame_done, vecs[i].fd);
            if (vecs[i].fs) begin
                fs = 1'b1;
                @(negedge clk);
                fs = 1'b0;
            end
        end
        wait_fd(2, k + 1600);
        repeat (5) @(negedge clk);
        chk("t6_loads", ld_win.size(), 8);
        chk("t6_fd_cnt", fd_win.size(), 2);
        if (fd_win.size() == 2) chk("t6_fd2_win", fd_win[1], k + 741 + 740);

        // Normal bit controller: single frame.
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        clear_q();
        k = cyc + 1;
        pulse_start(k - 1);
        wait_fd(1, k + 2500);
        repeat (5) @(negedge clk);
        chk("t2_loads", ld_dat.size(), 4);
        for (int i = 0; i < 4 && i < ld_dat.size(); i++) begin
            chk($sformatf("t2_dat%0d", i), ld_dat[i], words[i]);
            chk($sformatf("t2_ldwin%0d", i), ld_win[i], k + 2 + 292 * i);
        end
        chk("t2_rds", rd_adr.size(), 4);
        for (int i = 0; i < 4 && i < rd_adr.size(); i++)
            chk($sformatf("t2_addr%0d", i), rd_adr[i], i);
        chk("t2_fd_cnt", fd_win.size(), 1);
        if (fd_win.size() == 1) chk("t2_fd_win", fd_win[0], k + 2 + 3 * 292 + 290 + 720);

        // Three requests during a frame queue exactly one more.
        clear_q();
        k = cyc + 1;
        pulse_start(k - 1);
        pulse_start(k + 10);
        pulse_start(k + 300);
        pulse_start(k + 1500);
        wait_fd(2, k + 4200);
        repeat (40) @(negedge clk);
        chk("t3_loads", ld_win.size(), 8);
        chk("t3_fd_cnt", fd_win.size(), 2);
        if (fd_win.size() == 2) begin
            chk("t3_fd1_win", fd_win[0], k + 1888);
            chk("t3_fd2_win", fd_win[1], k + 1888 + 1 + 1888);
        end
        if (rd_win.size() == 8) chk("t3_f2_rd", rd_win[4], k + 1889);
        chk("t3_idle", bus.busy, 0);

        // Reset during the second word's SEND.
        clear_q();
        k = cyc + 1;
        pulse_start(k - 1);
        wait_until(k + 400);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("t5");
        r = cyc;
        reset = 1'b0;
        wait_until(r + 719);
        chk("t5_busy_last", bus.busy, 1);
        wait_until(r + 720);
        chk("t5_busy_fall", bus.busy, 0);
        wait_until(r + 730);
        chk("t5_no_fd", fd_win.size(), 0);
        chk("t5_loads", ld_win.size(), 2);
        clear_q();
        k = cyc + 1;
        pulse_start(k - 1);
        wait_fd(1, k + 2500);
        repeat (5) @(negedge clk);
        if (rd_adr.size() > 0) chk("t5_restart_addr", rd_adr[0], 0);
        if (rd_win.size() > 0) chk("t5_restart_win", rd_win[0], k);
        if (ld_dat.size() > 0) chk("t5_restart_dat", ld_dat[0], 24'h110000);
        chk("t5_fd_cnt", fd_win.size(), 1);

        chk("dbl_load", dbl_ld, 0);
        chk("dbl_fd", dbl_fd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
